// File: rtl/fifo_wr_arb_pkg.sv
// Shared state encoding and width helpers for the fifo_wr_arb write arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int grant_width(input int nreq);
      return (clog2(nreq) < 1) ? 1 : clog2(nreq);
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', wrapping.
module fifo_wr_arb_rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int GW   = grant_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last,
   output logic            any,
   output logic [GW-1:0]   idx
);
   localparam int SW = GW + 2;

   logic [SW-1:0]   w_start;
   logic [SW-1:0]   w_off;
   logic [SW-1:0]   w_sum;
   logic [NREQ-1:0] w_rot;

   // Shifting the doubled vector puts requester last+1 at bit 0.
   assign w_start = SW'(last) + SW'(1);
   assign w_rot   = NREQ'({req, req} >> w_start);
   assign any     = |req;

   // NOTE: give every always_comb output a default first so no latch is inferred.
   always_comb begin
      w_off = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_rot[j]) w_off = SW'(j);
      end
   end

   assign w_sum = w_start + w_off;
   assign idx   = (w_sum >= SW'(NREQ)) ? GW'(w_sum - SW'(NREQ)) : GW'(w_sum);

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-locked round-robin arbiter sharing one fifo_sync write port among NREQ requesters.
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int  NREQ      = 4,
   parameter int  DSIZE     = 8,
   parameter int  ASIZE     = 4,
   parameter int  MIN_SPACE = 1,
   localparam int GW        = grant_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       s_valid,
   input  logic [NREQ*DSIZE-1:0] s_data,
   input  logic [NREQ-1:0]       s_last,
   output logic [NREQ-1:0]       s_ready,
   output logic [DSIZE-1:0]      fifo_din,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   input  logic [ASIZE:0]        fifo_wr_count,
   output logic [GW-1:0]         grant_id,
   output logic                  busy
);
   localparam logic [ASIZE:0] DEPTH    = (ASIZE + 1)'(2 ** ASIZE);
   localparam logic [ASIZE:0] MIN_FREE = (ASIZE + 1)'(MIN_SPACE);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_last;
   logic [GW-1:0]   w_grant_nxt;
   logic [GW-1:0]   w_last_nxt;
   logic [ASIZE:0]  w_free;
   logic            w_space_ok;
   logic            w_pick_any;
   logic [GW-1:0]   w_pick_idx;

   assign w_free     = DEPTH - fifo_wr_count;
   assign w_space_ok = (w_free >= MIN_FREE);

   fifo_wr_arb_rr_pick #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_rr_pick (
      .req  (s_valid),
      .last (r_last),
      .any  (w_pick_any),
      .idx  (w_pick_idx)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= GW'(NREQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Handshake outputs depend only on registered state plus fifo_full, never on s_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      s_ready     = '0;
      fifo_wr_en  = 1'b0;
      fifo_din    = s_data[r_grant*DSIZE +: DSIZE];
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any && w_space_ok) begin
               w_grant_nxt = w_pick_idx;
               w_last_nxt  = w_pick_idx;
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            s_ready[r_grant] = ~fifo_full;
            fifo_wr_en       = s_valid[r_grant] & ~fifo_full;
            if (fifo_wr_en && s_last[r_grant]) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign grant_id = r_grant;
   assign busy     = (r_state == ST_XFER);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: packet sources, write scoreboard, one task per scenario.
module tb_fifo_wr_arb;
   localparam int NREQ      = 4;
   localparam int DSIZE     = 8;
   localparam int ASIZE     = 4;
   localparam int MIN_SPACE = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       s_valid;
   logic [NREQ*DSIZE-1:0] s_data;
   logic [NREQ-1:0]       s_last;
   logic [NREQ-1:0]       s_ready;
   logic [DSIZE-1:0]      fifo_din;
   logic                  fifo_wr_en;
   logic                  fifo_full;
   logic [ASIZE:0]        fifo_wr_count;
   logic [1:0]            grant_id;
   logic                  busy;

   int n_total = 0;
   int n_pass  = 0;

   int         src_rem [NREQ];
   int         src_plen[NREQ];
   int         src_bip [NREQ];
   int         src_seq [NREQ];
   bit         src_gap [NREQ];
   logic [7:0] got[$];

   always #5 clk = ~clk;

   fifo_wr_arb #(
      .NREQ      (NREQ),
      .DSIZE     (DSIZE),
      .ASIZE     (ASIZE),
      .MIN_SPACE (MIN_SPACE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_valid       (s_valid),
      .s_data        (s_data),
      .s_last        (s_last),
      .s_ready       (s_ready),
      .fifo_din      (fifo_din),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_full     (fifo_full),
      .fifo_wr_count (fifo_wr_count),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   // Beat payload: requester id in the top two bits, running beat number below.
   function automatic logic [7:0] beat(input int i, input int seq);
      return 8'(i * 64 + seq);
   endfunction

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         s_valid[i]       = (src_rem[i] > 0) && !src_gap[i];
         s_last[i]        = (src_bip[i] == src_plen[i] - 1) || (src_rem[i] == 1);
         s_data[i*8 +: 8] = beat(i, src_seq[i]);
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < NREQ; i++) begin
         src_rem[i]  = 0;
         src_plen[i] = 1;
         src_bip[i]  = 0;
         src_seq[i]  = 0;
         src_gap[i]  = 1'b0;
      end
   endtask

   task automatic load(input int i, input int beats, input int plen);
      src_rem[i]  = beats;
      src_plen[i] = plen;
      src_bip[i]  = 0;
   endtask

   // Sample handshakes and writes at negedge, advance sources after the posedge.
   task automatic cycle();
      bit hs[NREQ];
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) hs[i] = s_valid[i] && s_ready[i];
      if (fifo_wr_en) got.push_back(fifo_din);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (hs[i]) begin
            src_rem[i]--;
            src_seq[i]++;
            src_bip[i] = (src_bip[i] == src_plen[i] - 1) ? 0 : src_bip[i] + 1;
         end
      end
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      fifo_full     = 1'b0;
      fifo_wr_count = '0;
      clear_src();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      #1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      fifo_full     = 1'b0;
      fifo_wr_count = '0;
      clear_src();
      drive();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (s_ready !== 4'b0000) $display("FAIL reset_s_ready: got %b want 0000", s_ready);
      else n_pass++;
      n_total++;
      if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else n_pass++;
      n_total++;
      if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_id);
      else n_pass++;

      rst_n = 1'b1;
      load(2, 3, 3);
      drive();
      cycle();
      n_total++;
      if (grant_id !== 2'd2 || busy !== 1'b1)
         $display("FAIL reset_pre_grant: got id=%0d busy=%b want id=2 busy=1", grant_id, busy);
      else n_pass++;

      for (int i = 0; i < NREQ; i++) load(i, 3, 3);
      drive();
      #1;
      n_total++;
      if (s_ready !== 4'b0100 || fifo_wr_en !== 1'b1)
         $display("FAIL reset_mid_xfer: got ready=%b wr=%b want 0100/1", s_ready, fifo_wr_en);
      else n_pass++;

      rst_n = 1'b0;
      #1;
      n_total++;
      if (s_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_async: got ready=%b wr=%b busy=%b want 0000/0/0",
                  s_ready, fifo_wr_en, busy);
      else n_pass++;

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      cycle();
      n_total++;
      if (grant_id !== 2'd0 || busy !== 1'b1)
         $display("FAIL reset_first_grant: got id=%0d busy=%b want id=0 busy=1", grant_id, busy);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int   grants[$];
      logic prev_busy;
      int   exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < NREQ; i++) load(i, 10, 2);
      drive();
      #1;
      prev_busy = busy;
      for (int c = 1; c <= 13; c++) begin
         cycle();
         if (busy && !prev_busy) grants.push_back(int'(grant_id));
         prev_busy = busy;
         if (c == 12) begin
            n_total++;
            if (got.size() != 8) $display("FAIL rr_writes_12cyc: got %0d want 8", got.size());
            else n_pass++;
         end
      end
      n_total++;
      if (grants.size() != 5) $display("FAIL rr_grant_count: got %0d want 5", grants.size());
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_total++;
         if (k >= grants.size() || grants[k] != exp_order[k])
            $display("FAIL rr_grant%0d: got %0d want %0d", k,
                     (k < grants.size()) ? grants[k] : -1, exp_order[k]);
         else n_pass++;
      end
      for (int k = 0; k < 8; k++) begin
         n_total++;
         if (k >= got.size() || got[k] !== beat(k / 2, k % 2))
            $display("FAIL rr_data%0d: got %h want %h", k,
                     (k < got.size()) ? got[k] : 8'hxx, beat(k / 2, k % 2));
         else n_pass++;
      end
   endtask

   task automatic test_lock_gap();
      logic [7:0] exp_data[4];
      exp_data = '{beat(1, 0), beat(1, 1), beat(1, 2), beat(2, 0)};
      do_reset();
      load(1, 3, 3);
      load(2, 1, 1);
      drive();
      cycle();
      n_total++;
      if (grant_id !== 2'd1) $display("FAIL lock_grant: got %0d want 1", grant_id);
      else n_pass++;
      cycle();
      src_gap[1] = 1'b1;
      drive();
      for (int c = 0; c < 2; c++) begin
         cycle();
         n_total++;
         if (grant_id !== 2'd1 || busy !== 1'b1 || s_ready !== 4'b0010 || fifo_wr_en !== 1'b0)
            $display("FAIL lock_gap%0d: got id=%0d busy=%b ready=%b wr=%b want 1/1/0010/0",
                     c, grant_id, busy, s_ready, fifo_wr_en);
         else n_pass++;
      end
      src_gap[1] = 1'b0;
      drive();
      cycle();
      n_total++;
      if (grant_id !== 2'd1 || busy !== 1'b1)
         $display("FAIL lock_after_gap: got id=%0d busy=%b want 1/1", grant_id, busy);
      else n_pass++;
      cycle();
      n_total++;
      if (busy !== 1'b0) $display("FAIL lock_release: got busy=%b want 0", busy);
      else n_pass++;
      cycle();
      n_total++;
      if (grant_id !== 2'd2) $display("FAIL lock_next_grant: got %0d want 2", grant_id);
      else n_pass++;
      cycle();
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (k >= got.size() || got[k] !== exp_data[k])
            $display("FAIL lock_data%0d: got %h want %h", k,
                     (k < got.size()) ? got[k] : 8'hxx, exp_data[k]);
         else n_pass++;
      end
   endtask

   task automatic test_full_stall();
      int budget;
      do_reset();
      load(0, 4, 4);
      drive();
      cycle();
      cycle();
      fifo_full = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         n_total++;
         if (fifo_wr_en !== 1'b0 || s_ready !== 4'b0000 || busy !== 1'b1)
            $display("FAIL stall%0d: got wr=%b ready=%b busy=%b want 0/0000/1",
                     c, fifo_wr_en, s_ready, busy);
         else n_pass++;
         cycle();
      end
      fifo_full = 1'b0;
      budget = 10;
      while (src_rem[0] > 0 && budget > 0) begin
         cycle();
         budget--;
      end
      n_total++;
      if (src_rem[0] != 0) $display("FAIL stall_drain_timeout: got rem=%0d want 0", src_rem[0]);
      else n_pass++;
      n_total++;
      if (got.size() != 4) $display("FAIL stall_write_count: got %0d want 4", got.size());
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (k >= got.size() || got[k] !== beat(0, k))
            $display("FAIL stall_data%0d: got %h want %h", k,
                     (k < got.size()) ? got[k] : 8'hxx, beat(0, k));
         else n_pass++;
      end
   endtask

   task automatic test_space_gate();
      do_reset();
      fifo_wr_count = 5'd13;
      load(0, 1, 1);
      drive();
      #1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_total++;
         if (busy !== 1'b0 || s_ready !== 4'b0000)
            $display("FAIL space_hold%0d: got busy=%b ready=%b want 0/0000", c, busy, s_ready);
         else n_pass++;
      end
      fifo_wr_count = 5'd12;
      cycle();
      n_total++;
      if (busy !== 1'b1 || grant_id !== 2'd0)
         $display("FAIL space_grant: got busy=%b id=%0d want 1/0", busy, grant_id);
      else n_pass++;
      cycle();
      n_total++;
      if (got.size() != 1 || got[0] !== beat(0, 0))
         $display("FAIL space_data: got n=%0d want n=1 data=%h", got.size(), beat(0, 0));
      else n_pass++;
      fifo_wr_count = '0;
   endtask

   task automatic test_single_beat();
      do_reset();
      load(3, 3, 1);
      drive();
      for (int c = 0; c < 6; c++) begin
         cycle();
         n_total++;
         if (busy !== ((c % 2) == 0))
            $display("FAIL single_busy%0d: got %b want %b", c, busy, (c % 2) == 0);
         else n_pass++;
         if ((c % 2) == 0) begin
            n_total++;
            if (grant_id !== 2'd3) $display("FAIL single_grant%0d: got %0d want 3", c, grant_id);
            else n_pass++;
         end
         n_total++;
         if (got.size() != (c + 1) / 2)
            $display("FAIL single_writes%0d: got %0d want %0d", c, got.size(), (c + 1) / 2);
         else n_pass++;
      end
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (k >= got.size() || got[k] !== beat(3, k))
            $display("FAIL single_data%0d: got %h want %h", k,
                     (k < got.size()) ? got[k] : 8'hxx, beat(3, k));
         else n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_round_robin();
      test_lock_gap();
      test_full_stall();
      test_space_gate();
      test_single_beat();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
